// File: rtl/scrypt_romix_ctrl_pkg.sv
// scrypt_pkg: shared types and widths for the scrypt ROMix sequencer.
//   romix_state_t   controller state encoding
//   BLOCK_W         width of one scrypt block (X, V[i], blockmix data)
//   HALF_W          width of one BlockMix half
//   INTEGERIFY_LSB  bit position of the word that Integerify reads
package scrypt_pkg;

    localparam int BLOCK_W        = 1024;
    localparam int HALF_W         = 512;
    // First 32-bit word of the bottom 512-bit half, in this codebase's packing.
    localparam int INTEGERIFY_LSB = HALF_W - 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_ISSUE,
        ST_FILL_WAIT,
        ST_MIX_RD,
        ST_MIX_ISSUE,
        ST_MIX_WAIT,
        ST_DONE
    } romix_state_t;

endpackage

// File: rtl/scrypt_romix_ctrl_if.sv
// scrypt_romix_ctrl_if: bundles the three buses around the ROMix sequencer.
//   host side : start, data_in -> busy, done, result
//   blockmix  : bm_data, bm_enable -> bm_hash_out, bm_hash_done
//   scratchpad: mem_addr, mem_wdata, mem_we -> mem_rdata
// Modports:
//   master - the sequencer (drives blockmix/scratchpad, reports to host)
//   slave  - everything around it (host, blockmix, scratchpad RAM)
interface scrypt_romix_ctrl_if import scrypt_pkg::*; #(
    parameter int ADDR_W = 10
);
    logic                start;
    logic [BLOCK_W-1:0]  data_in;
    logic                busy;
    logic                done;
    logic [BLOCK_W-1:0]  result;

    logic [BLOCK_W-1:0]  bm_data;
    logic                bm_enable;
    logic [BLOCK_W-1:0]  bm_hash_out;
    logic                bm_hash_done;

    logic [ADDR_W-1:0]   mem_addr;
    logic [BLOCK_W-1:0]  mem_wdata;
    logic                mem_we;
    logic [BLOCK_W-1:0]  mem_rdata;

    modport master (
        input  start, data_in, bm_hash_out, bm_hash_done, mem_rdata,
        output busy, done, result, bm_data, bm_enable, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output start, data_in, bm_hash_out, bm_hash_done, mem_rdata,
        input  busy, done, result, bm_data, bm_enable, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/scrypt_romix_ctrl.sv
// scrypt_romix_ctrl: sequencer for the scrypt ROMix loop.
// Phase 1 stores V[i]=X and runs X=BlockMix(X) N times; phase 2 runs
// X=BlockMix(X ^ V[Integerify(X) mod N]) N times, then presents X as result.
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   io           scrypt_romix_ctrl_if.master (host, blockmix, scratchpad)
//   cycle_count  busy-cycle counter, present only with SCRYPT_ROMIX_CYCLE_COUNT_EN
// Optional build macro: SCRYPT_ROMIX_CYCLE_COUNT_EN
//
// state         | meaning
// --------------+----------------------------------------------------
// ST_IDLE       | waiting for start
// ST_FILL_ISSUE | write V[i]=X, launch BlockMix(X)
// ST_FILL_WAIT  | wait for blockmix, then next i or enter mix phase
// ST_MIX_RD     | present j=Integerify(X) to the scratchpad
// ST_MIX_ISSUE  | launch BlockMix(X ^ V[j]), latch that input
// ST_MIX_WAIT   | wait for blockmix, then next i or finish
// ST_DONE       | pulse done, latch result
module scrypt_romix_ctrl import scrypt_pkg::*; #(
    parameter int N      = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    scrypt_romix_ctrl_if.master io
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
    ,
    output logic [31:0]         cycle_count
`endif
);

    romix_state_t        r_state, w_state_nxt;
    logic [BLOCK_W-1:0]  r_x, r_xin, r_result;
    logic [ADDR_W-1:0]   r_i;

    logic                w_last;
    logic [ADDR_W-1:0]   w_j;
    logic [BLOCK_W-1:0]  w_mix_in;
    logic                w_busy, w_done, w_bm_enable, w_mem_we;
    logic [BLOCK_W-1:0]  w_bm_data, w_mem_wdata;
    logic [ADDR_W-1:0]   w_mem_addr;

    assign w_last   = (r_i == ADDR_W'(N - 1));
    assign w_j      = r_x[INTEGERIFY_LSB +: ADDR_W];
    // mem_rdata holds V[j] in MIX_ISSUE because MIX_RD presented j one cycle earlier.
    assign w_mix_in = r_x ^ io.mem_rdata;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state != ST_IDLE);
        w_done      = 1'b0;
        w_bm_enable = 1'b0;
        w_bm_data   = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io.start) w_state_nxt = ST_FILL_ISSUE;
            end
            ST_FILL_ISSUE: begin
                w_mem_addr  = r_i;
                w_mem_wdata = r_x;
                w_mem_we    = 1'b1;
                w_bm_data   = r_x;
                w_bm_enable = 1'b1;
                w_state_nxt = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                w_bm_data = r_x;
                if (io.bm_hash_done) w_state_nxt = w_last ? ST_MIX_RD : ST_FILL_ISSUE;
            end
            ST_MIX_RD: begin
                w_mem_addr  = w_j;
                w_state_nxt = ST_MIX_ISSUE;
            end
            ST_MIX_ISSUE: begin
                w_bm_data   = w_mix_in;
                w_bm_enable = 1'b1;
                w_state_nxt = ST_MIX_WAIT;
            end
            ST_MIX_WAIT: begin
                w_bm_data = r_xin;
                if (io.bm_hash_done) w_state_nxt = w_last ? ST_DONE : ST_MIX_RD;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x      <= '0;
            r_xin    <= '0;
            r_i      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io.start) begin
                        r_x <= io.data_in;
                        r_i <= '0;
                    end
                end
                ST_FILL_WAIT: begin
                    if (io.bm_hash_done) begin
                        r_x <= io.bm_hash_out;
                        r_i <= w_last ? '0 : r_i + ADDR_W'(1);
                    end
                end
                ST_MIX_ISSUE: r_xin <= w_mix_in;
                ST_MIX_WAIT: begin
                    if (io.bm_hash_done) begin
                        r_x <= io.bm_hash_out;
                        if (!w_last) r_i <= r_i + ADDR_W'(1);
                    end
                end
                ST_DONE: r_result <= r_x;
                default: ;
            endcase
        end
    end

    assign io.busy      = w_busy;
    assign io.done      = w_done;
    assign io.result    = r_result;
    assign io.bm_data   = w_bm_data;
    assign io.bm_enable = w_bm_enable;
    assign io.mem_addr  = w_mem_addr;
    assign io.mem_wdata = w_mem_wdata;
    assign io.mem_we    = w_mem_we;

`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cycle_count <= '0;
        end else if (r_state == ST_IDLE && io.start) begin
            r_cycle_count <= '0;
        end else if (w_busy && r_cycle_count != 32'hFFFF_FFFF) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_scrypt_romix_ctrl.sv
// tb_scrypt_romix_ctrl: directed bench for scrypt_romix_ctrl with N=4 and a
// behavioural blockmix (L=3, +1 on every 32-bit word) plus a 4-entry RAM.
module tb_scrypt_romix_ctrl import scrypt_pkg::*;;

    localparam int N   = 4;
    localparam int AW  = 2;
    localparam int L   = 3;
    localparam int LAT = 2 * N * (L + 1) + N + 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    scrypt_romix_ctrl_if #(.ADDR_W(AW)) io();
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    scrypt_romix_ctrl #(.N(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .io    (io)
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] bm_fn(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] r;
        for (int w = 0; w < 32; w++) r[w*32 +: 32] = x[w*32 +: 32] + 32'd1;
        return r;
    endfunction

    // blockmix model: done pulse L cycles after the enable cycle
    logic [BLOCK_W-1:0] bm_held, bm_out;
    logic [1:0]         bm_cnt;
    logic               bm_done;
    logic               spur = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bm_held <= '0;
            bm_out  <= '0;
            bm_cnt  <= '0;
            bm_done <= 1'b0;
        end else begin
            bm_done <= 1'b0;
            if (io.bm_enable) begin
                bm_held <= io.bm_data;
                bm_cnt  <= 2'(L - 1);
            end else if (bm_cnt != 0) begin
                bm_cnt <= bm_cnt - 2'd1;
                if (bm_cnt == 2'd1) begin
                    bm_done <= 1'b1;
                    bm_out  <= bm_fn(bm_held);
                end
            end
        end
    end

    assign io.bm_hash_out  = spur ? {BLOCK_W{1'b1}} : bm_out;
    assign io.bm_hash_done = bm_done | spur;

    logic [BLOCK_W-1:0] ram [N];
    always @(posedge clk) begin
        if (io.mem_we) ram[io.mem_addr] <= io.mem_wdata;
        io.mem_rdata <= ram[io.mem_addr];
    end

    // bus monitor
    logic [BLOCK_W-1:0] wr_data [16];
    logic [AW-1:0]      wr_addr [16];
    logic [BLOCK_W-1:0] en_data [16];
    logic [AW-1:0]      en_addr [16];
    logic [AW-1:0]      prev_addr = '0;
    int wr_cnt = 0, en_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (io.mem_we && wr_cnt < 16) begin
                wr_addr[wr_cnt] = io.mem_addr;
                wr_data[wr_cnt] = io.mem_wdata;
                wr_cnt++;
            end
            if (io.bm_enable && en_cnt < 16) begin
                en_addr[en_cnt] = prev_addr;
                en_data[en_cnt] = io.bm_data;
                en_cnt++;
            end
            if (io.done) done_cnt++;
        end
        prev_addr = io.mem_addr;
    end

    // software ROMix reference
    logic [BLOCK_W-1:0] exp_v [N];
    logic [BLOCK_W-1:0] exp_en [2*N];
    logic [AW-1:0]      exp_j [N];
    logic [BLOCK_W-1:0] exp_res;

    task automatic sw_model(input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] x;
        x = b;
        for (int i = 0; i < N; i++) begin
            exp_v[i]  = x;
            exp_en[i] = x;
            x = bm_fn(x);
        end
        for (int i = 0; i < N; i++) begin
            exp_j[i]    = x[INTEGERIFY_LSB +: AW];
            exp_en[N+i] = x ^ exp_v[exp_j[i]];
            x = bm_fn(exp_en[N+i]);
        end
        exp_res = x;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  io.busy, 0);
        check({tag, "_done"},  io.done, 0);
        check({tag, "_bmen"},  io.bm_enable, 0);
        check({tag, "_bmdat"}, io.bm_data, 0);
        check({tag, "_we"},    io.mem_we, 0);
        check({tag, "_addr"},  io.mem_addr, 0);
        check({tag, "_wdat"},  io.mem_wdata, 0);
        check({tag, "_res"},   io.result, 0);
    endtask

    // One operation. glitch_k/spur_k/rst_k name the post-accept cycle in which
    // to pulse a stray start, a stray bm_hash_done, or reset (0 = never).
    task automatic run_block(input string tag, input logic [BLOCK_W-1:0] b,
                             input int glitch_k, input int spur_k, input int rst_k);
        bit got_done;
        int lat;
        sw_model(b);
        got_done = 0;
        lat = 0;
        @(negedge clk);
        wr_cnt = 0; en_cnt = 0; done_cnt = 0;
        io.data_in = b;
        io.start   = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
            if (k == 1) check({tag, "_cc_clear"}, cycle_count, 0);
`endif
            io.start = (k == glitch_k);
            if (k == glitch_k) io.data_in = ~b;
            spur = (k == spur_k);
            if (k == rst_k) begin
                check({tag, "_busy_pre_rst"}, io.busy, 1);
                n_rst = 1'b0;
                #1 check_idle_outputs({tag, "_rst"});
                repeat (3) @(negedge clk);
                n_rst = 1'b1;
                repeat (2) @(negedge clk);
                check({tag, "_no_done"}, done_cnt, 0);
                check({tag, "_idle_after_rst"}, io.busy, 0);
                return;
            end
            if (io.done) begin
                got_done = 1;
                lat = k + 1;
                break;
            end
        end
        check({tag, "_done_seen"}, got_done, 1);
        if (!got_done) return;
        check({tag, "_latency"}, lat, LAT);
        @(negedge clk);
        io.start = 1'b0;
        spur = 1'b0;
        check({tag, "_result"}, io.result, exp_res);
        check({tag, "_busy_after"}, io.busy, 0);
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
        check({tag, "_cc"}, cycle_count, LAT - 1);
`endif
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_result_hold"}, io.result, exp_res);
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
        check({tag, "_cc_hold"}, cycle_count, LAT - 1);
`endif
        check({tag, "_wr_cnt"}, wr_cnt, N);
        check({tag, "_en_cnt"}, en_cnt, 2 * N);
        for (int i = 0; i < N && i < wr_cnt; i++) begin
            check($sformatf("%s_wr_addr%0d", tag, i), wr_addr[i], i);
            check($sformatf("%s_wr_data%0d", tag, i), wr_data[i], exp_v[i]);
        end
        for (int i = 0; i < 2 * N && i < en_cnt; i++)
            check($sformatf("%s_bm_in%0d", tag, i), en_data[i], exp_en[i]);
        for (int i = 0; i < N && N + i < en_cnt; i++)
            check($sformatf("%s_mix_j%0d", tag, i), en_addr[N+i], exp_j[i]);
    endtask

    logic [BLOCK_W-1:0] blk;

    initial begin
        io.start   = 1'b0;
        io.data_in = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        n_rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // data_in = 0: writes 0,1,2,3 per word, result 5 per word
        run_block("zero", '0, 0, 0, 0);
        check("zero_hand_result", io.result, {32{32'd5}});
        check("zero_hand_v3", wr_data[3], {32{32'd3}});

        // Integerify word = 2 -> X after fill has word 6 -> first j = 2
        blk = '0;
        blk[INTEGERIFY_LSB +: 32] = 32'd2;
        run_block("j2", blk, 0, 0, 0);
        check("j2_first_addr", en_addr[N], 2);

        // stray start during FILL_WAIT and during DONE
        blk = {32{32'h0BAD_F00D}};
        run_block("start_fill", blk, 3, 0, 0);
        run_block("start_done", blk, LAT - 1, 0, 0);

        // stray bm_hash_done in the first MIX_RD
        run_block("spur", {32{32'h1357_9BDF}}, 0, 4 * N + 1, 0);

        // reset in MIX_WAIT, then a clean run
        run_block("rst", {32{32'hA5A5_0003}}, 0, 0, 4 * N + 4);
        run_block("after_rst", {32{32'h7777_0001}}, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
